// File: rtl/register.sv
// register: load-enabled storage register with a one-cycle changed strobe.
// Optional parity protection when REGISTER_PARITY_EN is defined.
module register #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   output logic [WIDTH-1:0] out,
   output logic             changed
`ifdef REGISTER_PARITY_EN
   ,
   output logic             parity_err
`endif
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         out     <= RESET_VALUE;
         changed <= 1'b0;
      end else begin
         changed <= load && (in != out);
         if (load) out <= in;
      end
`ifdef REGISTER_PARITY_EN
   logic parity_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) parity_q <= ^RESET_VALUE;
      else if (load) parity_q <= ^in;
   // Any single flipped bit in out or parity_q makes these disagree.
   assign parity_err = (^out) ^ parity_q;
`endif
endmodule

// File: tb/tb_register.sv
// tb_register: randomized self-checking bench for register against a simple behavioural model.
module tb_register;
   localparam int W = 32;
`ifdef REGISTER_PARITY_EN
   localparam logic [W-1:0] RV = 32'hA5A5A5A5;
`else
   localparam logic [W-1:0] RV = 32'h0;
`endif
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in = '0;
   logic         load = 1'b0;
   logic [W-1:0] out;
   logic         changed;
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] exp_out;
   logic         exp_changed;
`ifdef REGISTER_PARITY_EN
   logic         parity_err;
`endif

   register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
      .clk(clk), .rst(rst), .in(in), .load(load), .out(out), .changed(changed)
`ifdef REGISTER_PARITY_EN
      , .parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input logic l, input logic [W-1:0] d);
      load = l;
      in   = d;
      exp_changed = l && (d != exp_out);
      if (l) exp_out = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      load = 1'b1;
      in   = 32'hDEADBEEF;
      rst  = 1'b0;
      #1;
      checks++;
      if (out !== RV) begin errors++; $display("FAIL async_reset out=%h exp=%h", out, RV); end
      checks++;
      if (changed !== 1'b0) begin errors++; $display("FAIL async_reset changed=%b exp=0", changed); end
      @(posedge clk);
      #1;
      checks++;
      if (out !== RV) begin errors++; $display("FAIL reset_held out=%h exp=%h", out, RV); end
      exp_out = RV;
      exp_changed = 1'b0;
   endtask

   task automatic test_load;
      rst = 1'b1;
      step(1'b1, 32'hDEADBEEF);
      checks++;
      if (out !== 32'hDEADBEEF) begin errors++; $display("FAIL load out=%h exp=deadbeef", out); end
      checks++;
      if (changed !== 1'b1) begin errors++; $display("FAIL load_changed changed=%b exp=1", changed); end
      step(1'b1, 32'h0000BABE);
      checks++;
      if (out !== 32'h0000BABE || changed !== 1'b1) begin
         errors++; $display("FAIL update out=%h changed=%b exp=0000babe/1", out, changed);
      end
      step(1'b1, 32'h0000BABE);
      checks++;
      if (out !== 32'h0000BABE || changed !== 1'b0) begin
         errors++; $display("FAIL same_value out=%h changed=%b exp=0000babe/0", out, changed);
      end
   endtask

   task automatic test_hold;
      step(1'b1, 32'h12345678);
      step(1'b1, 32'h0000BABE);
      step(1'b0, 32'hDEADBEEF);
      checks++;
      if (out !== 32'h0000BABE || changed !== 1'b0) begin
         errors++; $display("FAIL hold_first out=%h changed=%b exp=0000babe/0", out, changed);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h1111BABE);
         checks++;
         if (out !== 32'h0000BABE || changed !== 1'b0) begin
            errors++; $display("FAIL hold out=%h changed=%b exp=0000babe/0", out, changed);
         end
      end
   endtask

   task automatic test_reset_mid;
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (out !== RV || changed !== 1'b0) begin
         errors++; $display("FAIL reset_mid out=%h changed=%b exp=%h/0", out, changed, RV);
      end
      load = 1'b1;
      in   = 32'h1111BABE;
      @(posedge clk);
      #1;
      checks++;
      if (out !== RV) begin errors++; $display("FAIL reset_priority out=%h exp=%h", out, RV); end
      rst = 1'b1;
      exp_out = RV;
      step(1'b1, 32'h1111BABE);
      checks++;
      if (out !== 32'h1111BABE || changed !== 1'b1) begin
         errors++; $display("FAIL reload out=%h changed=%b exp=1111babe/1", out, changed);
      end
   endtask

   task automatic test_back_to_back;
      step(1'b1, 32'hAAAA0001);
      step(1'b1, 32'hAAAA0002);
      checks++;
      if (out !== 32'hAAAA0002 || changed !== 1'b1) begin
         errors++; $display("FAIL back_to_back out=%h changed=%b exp=aaaa0002/1", out, changed);
      end
      step(1'b0, 32'h0);
      checks++;
      if (changed !== 1'b0) begin errors++; $display("FAIL strobe_clear changed=%b exp=0", changed); end
   endtask

   task automatic test_random;
      logic [W-1:0] d;
      for (int i = 0; i < 200; i++) begin
         d = ($urandom_range(0, 3) == 0) ? exp_out : W'($urandom);
         step(1'($urandom_range(0, 1)), d);
         checks++;
         if (out !== exp_out || changed !== exp_changed) begin
            errors++;
            $display("FAIL random[%0d] out=%h changed=%b exp=%h/%b", i, out, changed, exp_out, exp_changed);
         end
      end
   endtask

`ifdef REGISTER_PARITY_EN
   task automatic test_parity;
      #2;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      exp_out = RV;
      checks++;
      if (out !== RV || parity_err !== 1'b0) begin
         errors++; $display("FAIL parity_reset out=%h perr=%b exp=%h/0", out, parity_err, RV);
      end
      load = 1'b0;
      force dut.out = RV ^ 32'h1;
      #1;
      checks++;
      if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_flip perr=%b exp=1", parity_err); end
      @(negedge clk);
      release dut.out;
      step(1'b1, 32'h13572468);
      checks++;
      if (parity_err !== 1'b0 || out !== 32'h13572468) begin
         errors++; $display("FAIL parity_load out=%h perr=%b exp=13572468/0", out, parity_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef REGISTER_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
